sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the sdram controller (clk_p domain).
//  Shares the single SDRAM controller between port 0 (CPU/bus bridge) and port 1 (DMA/disk buffer).
//  Each port uses a stb/we/sel/ack handshake. Requests are granted round-robin.
//  Drives the controller's level rd/we strobes and masks the stale ready from the previous access.
//  Aborts a hung access with a timeout.
// PARAMETERS
//  AW       21   word address width; port addresses are [AW:1]
//  DW       16   data width
//  TIMEOUT  255  WAIT-state cycle limit before abort; 0 = watchdog disabled
// PORTS
//  clk_p          in   1    system clock, same as sdram controller clock
//  reset          in   1    asynchronous, active-high reset
//  mem_init_done  in   1    sdram initialised; no grant is issued while low
//  m0_stb/m1_stb  in   1    request; held high until the matching ack
//  m0_we/m1_we    in   1    1 = write, 0 = read
//  m0_sel/m1_sel  in   2    byte enables; bit1 = high byte, bit0 = low byte
//  m0_adr/m1_adr  in   AW   word address [AW:1]
//  m0_dat_i/m1_dat_i  in   DW   write data
//  m0_dat_o/m1_dat_o  out  DW   read data; valid in the ack cycle, held until the next read completes on that port
//  m0_ack/m1_ack  out  1    one-cycle completion pulse
//  mem_rd         out  1    level read request to the controller
//  mem_we         out  1    level write request to the controller
//  mem_sel        out  2    byte enables to the controller (wtbt)
//  mem_adr        out  AW   word address to the controller
//  mem_dout       out  DW   write data to the controller (din)
//  mem_din        in   DW   read data from the controller (dout)
//  mem_ready      in   1    controller ready / data valid
//  grant          out  2    one-hot owner of the current access; 00 when idle
//  timeout_err    out  1    one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, last_owner = 1 (port 0 wins the first tie), watchdog = 0.
//  Reset mid-access drops mem_rd/mem_we asynchronously; no ack is issued.
//  FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs are registered.
//  IDLE:
//   - requires mem_init_done = 1 and at least one stb.
//   - Single requester wins.
//   - Both requesting: the winner is the port != last_owner.
//   - Register owner, adr, we, sel, dat_i into the mem_* outputs.
//   - Set mem_rd = ~we or mem_we = we, set grant. Next state ISSUE.
//  ISSUE (exactly 1 cycle):
//   - mem_ready is ignored (stale from the previous access). Next state WAIT, watchdog cleared.
//  WAIT:
//   - Normal completion, mem_ready = 1:
//     - if read, latch mem_din into the owner's dat_o;
//     - clear mem_rd/mem_we; set last_owner = owner; next state ACK.
//   - Watchdog:
//     - increments each cycle; at the count TIMEOUT (TIMEOUT != 0), abort;
//     - clear mem_rd/mem_we; a read loads dat_o = all-ones;
//     - pulse timeout_err; next state ACK.
//  ACK:
//   - the owner's ack = 1 for one cycle; grant cleared; next state IDLE.
//   - The non-owner never sees ack.
//  Latency: stb seen in IDLE at cycle N -> mem_rd/mem_we high N+1 .. R, where R = first cycle >= N+2 with mem_ready = 1.
//   The owner's ack pulses at R+1. Minimum total is 3 cycles from the grant to the ack.
//  The request (adr/sel/data) is sampled once at grant; changes afterwards are ignored until ack.
//  mem_init_done falling mid-access does not abort; it only blocks new grants.
//  A stb dropped before its ack (protocol violation) does not cancel the access; the ack still pulses.
//  Both ports requesting continuously: grants strictly alternate 0,1,0,1.
//  mem_sel = 00 is passed unchanged (the controller decides by the address).
// TESTING
//  1 Reset: assert reset mid-WAIT -> mem_rd = 0, grant = 00, no ack; after release, port 0 wins the first tie.
//  2 m0 read adr = 0x00100, mem_ready at the 4th WAIT cycle with mem_din = 0x1234 -> m0_ack one cycle later; m0_dat_o = 0x1234; mem_rd high for exactly 5 cycles.
//  3 Stale ready: mem_ready held 1 throughout -> ISSUE still lasts 1 cycle; the ack comes 3 cycles after the grant, never 2.
//  4 m0 and m1 stb held for 6 accesses (m1 write sel = 10, dat = 0xABCD) -> grants 0,1,0,1,0,1; mem_sel = 10 and mem_dout = 0xABCD on m1 accesses.
//  5 TIMEOUT = 8, mem_ready stuck at 0 on an m1 read -> timeout_err pulse; m1_ack with m1_dat_o = 0xFFFF; the next m0 request is then served normally.
//  6 mem_init_done = 0 with m0_stb = 1 for 20 cycles -> no mem_rd; raising init_done -> mem_rd on the next cycle.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the SDRAM controller.
// Masks the stale ready left over from the previous access and aborts hung accesses.
// state  | meaning
// IDLE   | waiting for init_done and a request; picks the owner
// ISSUE  | first cycle of the access; controller ready is still stale
// WAIT   | rd/we held until ready or watchdog expiry
// ACK    | one-cycle ack to the owner
module sdram_arbiter #(
  parameter int AW      = 21,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_p,
  input  logic          reset,
  input  logic          mem_init_done,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [1:0]    m0_sel,
  input  logic [AW:1]   m0_adr,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [1:0]    m1_sel,
  input  logic [AW:1]   m1_adr,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [1:0]    mem_sel,
  output logic [AW:1]   mem_adr,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  input  logic          mem_ready,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic [WW-1:0] wdog;
  logic          pick;

  // On a tie the port that did not complete last wins.
  always_comb begin
    pick = 1'b0;
    if (m0_stb && m1_stb) pick = ~last_owner;
    else                  pick = m1_stb;
  end

  always_ff @(posedge clk_p or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      wdog        <= '0;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      mem_sel     <= 2'b00;
      mem_adr     <= '0;
      mem_dout    <= '0;
      grant       <= 2'b00;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_dat_o    <= '0;
      m1_dat_o    <= '0;
      timeout_err <= 1'b0;
    end else begin
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_init_done && (m0_stb || m1_stb)) begin
            owner    <= pick;
            mem_adr  <= pick ? m1_adr   : m0_adr;
            mem_sel  <= pick ? m1_sel   : m0_sel;
            mem_dout <= pick ? m1_dat_i : m0_dat_i;
            mem_we   <= pick ? m1_we    : m0_we;
            mem_rd   <= pick ? ~m1_we   : ~m0_we;
            grant    <= pick ? 2'b10    : 2'b01;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (mem_rd) begin
              if (owner) m1_dat_o <= mem_din;
              else       m0_dat_o <= mem_din;
            end
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
            last_owner <= owner;
            m0_ack     <= ~owner;
            m1_ack     <= owner;
            state      <= S_ACK;
          end else if ((TIMEOUT != 0) && (wdog == WD_LIMIT)) begin
            // Abort: reads return all-ones so the master sees a recognisable value.
            if (mem_rd) begin
              if (owner) m1_dat_o <= '1;
              else       m0_dat_o <= '1;
            end
            mem_rd      <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            m0_ack      <= ~owner;
            m1_ack      <= owner;
            state       <= S_ACK;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_ACK: begin
          grant <= 2'b00;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
